// File: rtl/note_player_if.sv
// rtl/note_player_if.sv - note_player control, frequency-ROM and sample-path signal bundle
interface note_player_if #(
  parameter int STEP_BITS = 20,
  parameter int ADDR_BITS = 10
);
  logic                 play;
  logic                 new_note;
  logic [5:0]           note;
  logic [5:0]           duration;
  logic                 beat;
  logic                 generate_next_sample;
  logic [STEP_BITS-1:0] step_size;
  logic [5:0]           freq_addr;
  logic [ADDR_BITS-1:0] phase_addr;
  logic                 muted;
  logic                 note_done;

  modport master (
    output play, new_note, note, duration, beat, generate_next_sample, step_size,
    input  freq_addr, phase_addr, muted, note_done
  );

  modport slave (
    input  play, new_note, note, duration, beat, generate_next_sample, step_size,
    output freq_addr, phase_addr, muted, note_done
  );
endinterface

// File: rtl/note_player.sv
// rtl/note_player.sv - plays one note: fetches its phase step, runs the phase accumulator
// for the note's beat count, then pulses note_done back to the song reader.
module note_player #(
  parameter int PHASE_BITS = 22,
  parameter int STEP_BITS  = 20,
  parameter int ADDR_BITS  = 10
) (
  input  logic          clk,
  input  logic          reset,
  note_player_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LATCH,
    S_PLAY,
    S_DONE
  } state_e;

  state_e                state_q, state_d;
  logic [5:0]            freq_addr_q, freq_addr_d;
  logic [5:0]            note_q, note_d;
  logic [5:0]            remaining_q, remaining_d;
  logic [STEP_BITS-1:0]  step_q, step_d;
  logic [PHASE_BITS-1:0] phase_q, phase_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      freq_addr_q <= '0;
      note_q      <= '0;
      remaining_q <= '0;
      step_q      <= '0;
      phase_q     <= '0;
    end else begin
      state_q     <= state_d;
      freq_addr_q <= freq_addr_d;
      note_q      <= note_d;
      remaining_q <= remaining_d;
      step_q      <= step_d;
      phase_q     <= phase_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    freq_addr_d = freq_addr_q;
    note_d      = note_q;
    remaining_d = remaining_q;
    step_d      = step_q;
    phase_d     = phase_q;

    case (state_q)
      S_IDLE: begin
        if (bus.new_note) begin
          freq_addr_d = bus.note;
          note_d      = bus.note;
          remaining_d = bus.duration;
          state_d     = S_FETCH;
        end
      end
      S_FETCH: state_d = S_LATCH;
      S_LATCH: begin
        // A rest keeps a zero step so the accumulator stays parked at 0.
        step_d  = (note_q == 6'd0) ? '0 : bus.step_size;
        phase_d = '0;
        state_d = (remaining_q == 6'd0) ? S_DONE : S_PLAY;
      end
      S_PLAY: begin
        if (bus.play && bus.generate_next_sample) begin
          phase_d = phase_q + PHASE_BITS'(step_q);
        end
        if (bus.play && bus.beat) begin
          if (remaining_q == 6'd1) begin
            state_d = S_DONE;
          end else begin
            remaining_d = remaining_q - 6'd1;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.freq_addr  = freq_addr_q;
  assign bus.phase_addr = phase_q[PHASE_BITS-1 -: ADDR_BITS];
  assign bus.note_done  = (state_q == S_DONE);
  assign bus.muted      = !((state_q == S_PLAY) && bus.play && (note_q != 6'd0));

endmodule

// File: doc/note_player.md
# note_player

Downstream stage of the song reader. Accepts one note (pitch index and beat-count duration) per `new_note` pulse and fetches its phase step from the external clocked frequency ROM. It advances a phase accumulator once per audio sample request for the note's duration, counted in `beat` pulses, then returns a one-cycle `note_done` pulse. That pulse advances the song reader's address counter and triggers the next `new_note`.

## Interface
Parameters:
- `PHASE_BITS`, 22: phase accumulator width.
- `STEP_BITS`, 20: width of the step size returned by the frequency ROM; must be ≤ `PHASE_BITS`.
- `ADDR_BITS`, 10: width of `phase_addr`, the top bits of the accumulator, sent to the sine ROM.

Ports:
- `clk`  in  1  system clock.
- `reset`  in  1  synchronous, active-high reset, sampled on the `clk` rising edge.
- `play`  in  1  1 = run; 0 = pause, which freezes duration count and accumulator.
- `new_note`  in  1  one-cycle pulse; `note` and `duration` are valid in the same cycle.
- `note`  in  6  pitch index; 0 = rest.
- `duration`  in  6  length in beats; 0 = end-of-song marker.
- `beat`  in  1  one-cycle tempo pulse.
- `generate_next_sample`  in  1  one-cycle sample-rate request.
- `step_size`  in  `STEP_BITS`  frequency ROM data, valid one cycle after `freq_addr`.
- `freq_addr`  out  6  frequency ROM address (registered).
- `phase_addr`  out  `ADDR_BITS`  equals `phase[PHASE_BITS-1 -: ADDR_BITS]`.
- `muted`  out  1  1 = the sample path must output zero.
- `note_done`  out  1  one-cycle pulse at the end of a note.

## Operation
- States: IDLE, FETCH, LATCH, PLAY, DONE.
- IDLE
  - On `new_note`: register `freq_addr<=note`, `note_reg<=note`, `remaining<=duration`; go to FETCH.
  - Otherwise stay in IDLE.
- FETCH: wait one cycle for the ROM read; go to LATCH.
- LATCH
  - `step_reg <= (note_reg==0) ? 0 : step_size`; `phase <= 0`.
  - If `remaining==0`, go to DONE; otherwise go to PLAY.
- PLAY
  - If `play` and `generate_next_sample`: `phase <= phase + step_reg`, zero-extended to `PHASE_BITS` and wrapping modulo 2^`PHASE_BITS`.
  - If `play` and `beat` and `remaining==1`: go to DONE.
  - Else if `play` and `beat`: `remaining <= remaining-1`.
  - When `play==0`, `phase` and `remaining` hold.
- DONE: `note_done=1` for exactly this cycle; go to IDLE.
- `muted` = 1 unless state==PLAY, `play==1` and `note_reg!=0`. Rests run the full duration silently.
- `new_note` outside IDLE is ignored; the song reader never issues it before `note_done`.
- `beat` and `generate_next_sample` in FETCH, LATCH, DONE or IDLE have no effect.
- When `beat` and `generate_next_sample` coincide in PLAY, both take effect in the same cycle, including on the final beat.
- Reset (any state, mid-note included) forces:
  - state IDLE;
  - `remaining=0`, `step_reg=0`, `phase=0`, `freq_addr=0`;
  - `note_done=0`, `muted=1`.

## Timing
- Reset values: `freq_addr=0`, `phase_addr=0`, `muted=1`, `note_done=0`.
- `new_note` at cycle t:
  - FETCH at t+1, with `freq_addr` valid;
  - LATCH at t+2, where `step_size` is sampled;
  - PLAY from t+3, where `phase` first updates on a request.
- Duration N≥1 with `play` held high: `note_done` asserts in the cycle after the clock edge that samples the Nth PLAY-state `beat`.
- Duration 0: `note_done` at t+3; no PLAY cycle; `muted` stays 1.
- Back-to-back notes: earliest next `new_note` is the cycle after `note_done`, since the song reader sees the pulse, steps its address and reads its ROM. The block accepts `new_note` any time in IDLE.
- `note_done` is registered (a Moore output of DONE) and never asserts for two consecutive cycles.

## Test plan
- Reset, then no input for 10 cycles -> `note_done`=0, `muted`=1, `phase_addr`=0, `freq_addr`=0 throughout.
- `new_note` with note=5, duration=3; ROM model returns step_size=0x1000; `beat` every 20 cycles; `generate_next_sample` every 4 cycles -> `freq_addr`=5 at t+1; `phase` steps by 0x1000 per request; `note_done` single pulse after the 3rd beat; `muted`=0 only during PLAY.
- Accumulator wrap: step_size=0xFFFFF with `phase` preloaded near 2^22 via repeated requests -> `phase` wraps modulo 2^22 with no stall.
- Rest note=0, duration=2 -> `muted`=1 and `phase` constant at 0 for the whole note; `note_done` after the 2nd beat.
- Pause: drop `play` mid-note for 3 beats and 10 sample requests -> `remaining` and `phase` unchanged, `muted`=1; after `play` returns, exactly the outstanding beats elapse before `note_done`.
- Duration=0 -> `note_done` at t+3. Second case: assert `reset` in PLAY with `remaining`=4 -> next cycle IDLE, all outputs at reset values, no `note_done`.
